// File: rtl/div_unit_pkg.sv
// div_unit shared definitions: divide opcodes and the op decoder.
// Opcode values match the execute-stage ALU encoding.
package div_unit_pkg;

   localparam logic [4:0] ALU_DIV  = 5'd16;
   localparam logic [4:0] ALU_DIVU = 5'd17;
   localparam logic [4:0] ALU_REM  = 5'd18;
   localparam logic [4:0] ALU_REMU = 5'd19;

   typedef struct packed {
      logic valid;
      logic sgn;
      logic rem;
   } div_op_t;

   function automatic div_op_t decode_op(input logic [4:0] op);
      div_op_t d;
      d = '0;
      unique case (1'b1)
         (op == ALU_DIV):  d = '{valid: 1'b1, sgn: 1'b1, rem: 1'b0};
         (op == ALU_DIVU): d = '{valid: 1'b1, sgn: 1'b0, rem: 1'b0};
         (op == ALU_REM):  d = '{valid: 1'b1, sgn: 1'b1, rem: 1'b1};
         (op == ALU_REMU): d = '{valid: 1'b1, sgn: 1'b0, rem: 1'b1};
         default:          d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, and shift the quotient bit into dq.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] dq_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] dq_o
);

   logic [W:0] shf;
   logic [W:0] dif;

   // remainder stays below the divisor, so W+1 bits hold the shift
   always_comb begin
      shf = {rem_i, dq_i[W-1]};
      dif = shf - {1'b0, dvs_i};
      if (!dif[W]) begin
         rem_o = dif[W-1:0];
         dq_o  = {dq_i[W-2:0], 1'b1};
      end else begin
         rem_o = shf[W-1:0];
         dq_o  = {dq_i[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow complete on a one-cycle fast path.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [4:0]      alu_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONE = '1;

   state_e          state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] dq_q, dq_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic            is_rem_q, is_rem_d;
   logic            sa_q, sa_d;
   logic            sb_q, sb_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   div_op_t         op;
   logic            accept;
   logic            neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN-1:0] q_fix, r_fix;
   logic [XLEN-1:0] step_rem, step_dq;

   div_step #(.W(XLEN)) u_step (
      .rem_i (rem_q),
      .dq_i  (dq_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .dq_o  (step_dq)
   );

   // next-state, datapath and registered-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dq_d     = dq_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      is_rem_d = is_rem_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      result_d = result_q;

      op     = decode_op(alu_op);
      neg_a  = op.sgn & a[XLEN-1];
      neg_b  = op.sgn & b[XLEN-1];
      mag_a  = neg_a ? -a : a;
      mag_b  = neg_b ? -b : b;
      accept = start & op.valid &
               ((state_q == S_IDLE) | (state_q == S_DONE));
      q_fix  = (sa_q ^ sb_q) ? -dq_q : dq_q;
      r_fix  = sa_q ? -rem_q : rem_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               is_rem_d = op.rem;
               sa_d     = neg_a;
               sb_d     = neg_b;
               dq_d     = mag_a;
               dvs_d    = mag_b;
               rem_d    = '0;
               cnt_d    = '0;
               if (b == '0) begin
                  result_d = op.rem ? a : ALL_ONE;
                  state_d  = S_DONE;
               end else if (op.sgn && a == MIN_NEG &&
                            b == ALL_ONE) begin
                  result_d = op.rem ? '0 : MIN_NEG;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d = step_rem;
            dq_d  = step_dq;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            result_d = is_rem_q ? r_fix : q_fix;
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end

      busy_d = (state_d == S_CALC) | (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         dq_q     <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         is_rem_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dq_q     <= dq_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         is_rem_q <= is_rem_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, random ops
// against an arithmetic reference, flush, reset and control checks.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  alu_op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   div_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .alu_op  (alu_op),
      .a       (a),
      .b       (b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [4:0] op,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
      int signed sx;
      int signed sy;
      bit ovf;
      sx  = signed'(x);
      sy  = signed'(y);
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      if (op == ALU_DIVU) return (y == 0) ? 32'hFFFF_FFFF : x / y;
      if (op == ALU_REMU) return (y == 0) ? x : x % y;
      if (op == ALU_DIV) begin
         if (y == 0) return 32'hFFFF_FFFF;
         if (ovf) return 32'h8000_0000;
         return 32'(sx / sy);
      end
      if (y == 0) return x;
      if (ovf) return 32'h0;
      return 32'(sx % sy);
   endfunction

   function automatic bit is_fast(input logic [4:0] op,
                                  input logic [31:0] x,
                                  input logic [31:0] y);
      bit sgn;
      sgn = (op == ALU_DIV) || (op == ALU_REM);
      return (y == 0) ||
             (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
   endfunction

   // called mid-cycle; returns at #1 after the edge where done is seen
   task automatic run(input string tag, input logic [4:0] op,
                      input logic [31:0] x, input logic [31:0] y,
                      input int inj);
      int lat;
      int bcnt;
      logic [31:0] res;
      logic both;
      logic [31:0] exp;
      bit fast;
      lat  = -1;
      bcnt = 0;
      both = 1'b0;
      res  = 'x;
      exp  = ref_model(op, x, y);
      fast = is_fast(op, x, y);
      start  = 1'b1;
      alu_op = op;
      a      = x;
      b      = y;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (busy && done) both = 1'b1;
         if (busy) bcnt++;
         if (done) begin
            lat = c;
            res = result;
            break;
         end
         if (c == inj) begin
            start  = 1'b1;
            alu_op = ALU_DIVU;
            a      = 32'd1;
            b      = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check({tag, " result"}, res, exp);
      check({tag, " latency"}, lat, fast ? 1 : 34);
      check({tag, " busy_cycles"}, bcnt, fast ? 0 : 33);
      check({tag, " busy_done_overlap"}, {31'b0, both}, 32'd0);
   endtask

   task automatic count_dones(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
   endtask

   initial begin
      logic [31:0] prev;
      int dcnt;
      logic [4:0]  rop;
      logic [31:0] rx, ry;

      repeat (3) @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", result, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      run("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 0);
      run("remu 100/7", ALU_REMU, 32'd100, 32'd7, 0);
      run("div -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      run("rem -7/2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 0);
      run("div 7/-2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 0);
      run("rem 7/-2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 0);
      run("div 5/0", ALU_DIV, 32'd5, 32'd0, 0);
      run("remu 5/0", ALU_REMU, 32'd5, 32'd0, 0);
      run("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run("divu big", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run("b2b first", ALU_DIVU, 32'd1000, 32'd3, 0);
      run("b2b second", ALU_REM, 32'hFFFF_FC18, 32'd7, 0);
      run("start in busy", ALU_DIV, 32'hFFFF_FF00, 32'd5, 5);

      for (int i = 0; i < 40; i++) begin
         rop = ALU_DIV + 5'($urandom_range(0, 3));
         rx  = $urandom;
         ry  = $urandom;
         case ($urandom_range(0, 7))
            0: ry = 32'd0;
            1: ry = 32'hFFFF_FFFF;
            2: ry = $urandom_range(1, 15);
            3: rx = 32'h8000_0000;
            default: ;
         endcase
         run($sformatf("rand%0d", i), rop, rx, ry, 0);
      end

      @(negedge clk);
      prev   = result;
      start  = 1'b1;
      alu_op = ALU_DIVU;
      a      = 32'd1000;
      b      = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy", {31'b0, busy}, 32'd0);
      check("flush done", {31'b0, done}, 32'd0);
      check("flush result", result, prev);
      count_dones(40, dcnt);
      check("flush no done", dcnt, 32'd0);
      check("flush result held", result, prev);

      @(negedge clk);
      start  = 1'b1;
      alu_op = 5'd0;
      a      = 32'd8;
      b      = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      check("bad op busy", {31'b0, busy}, 32'd0);
      count_dones(5, dcnt);
      check("bad op no done", dcnt, 32'd0);

      @(negedge clk);
      start  = 1'b1;
      alu_op = ALU_DIVU;
      a      = 32'hFFFF_FFFF;
      b      = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      check("midreset busy", {31'b0, busy}, 32'd0);
      check("midreset done", {31'b0, done}, 32'd0);
      check("midreset result", result, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      count_dones(40, dcnt);
      check("midreset no done", dcnt, 32'd0);
      @(negedge clk);
      run("post reset divu 9/3", ALU_DIVU, 32'd9, 32'd3, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the RV32M DIV, DIVU, REM and REMU instructions. It is the sequential replacement for the single-cycle divide path in the execute stage: the stage issues an operation with a one-cycle start pulse, holds the pipeline while busy is high, and captures the result on a one-cycle done pulse. It uses radix-2 restoring division with one quotient bit per cycle. The RISC-V divide-by-zero and signed-overflow cases complete on a fast path.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse, sampled on clk; accepted only in IDLE or DONE.
- alu_op  in  5  operation code; ALU_DIV, ALU_DIVU, ALU_REM or ALU_REMU; any other code with start is ignored.
- a  in  32  dividend; sampled with start.
- b  in  32  divisor; sampled with start.
- flush  in  1  synchronous abort of any in-flight operation.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; result is valid.
- result  out  32  quotient or remainder; holds its value until the next done.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset forces state = IDLE, busy = 0, done = 0, result = 0, and clears the internal registers.
- Accept: in IDLE or DONE, start = 1 with a valid alu_op latches the following:
  - operation kind: signed or unsigned, quotient or remainder;
  - operand signs, sa = a[31] and sb = b[31], for signed ops only (zero for unsigned ops);
  - operand magnitudes: |a| and |b| for signed ops, raw a and b for unsigned ops. The magnitude of 0x80000000 is 0x80000000, read as unsigned.
- Fast path, taken on accept instead of entering CALC. The result is registered directly and the next state is DONE.
  - b == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed op with a == 0x80000000 and b == 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC: 32 iterations, counter 0..31, one per cycle.
  - Shift the 33-bit partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor. If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - When the counter reaches 31, go to FIX.
- FIX: apply signs and register the result. Next state is DONE.
  - Quotient is negated when sa ^ sb.
  - Remainder is negated when sa.
  - DIV/DIVU output the quotient; REM/REMU output the remainder.
- DONE: done = 1 for exactly this cycle.
  - A start in this cycle is accepted, giving back-to-back operations.
  - Otherwise the next state is IDLE.
- start in CALC or FIX is ignored. The caller must wait for done.
- flush: from any state, the next state is IDLE.
  - No done is produced and result is not updated.
  - flush has priority over start in the same cycle.
- A reset_n assertion mid-operation aborts immediately. No done is produced.

## Timing
- The start cycle is cycle 0.
- Normal path:
  - busy is high in cycles 1..33: CALC in cycles 1..32, FIX in cycle 33.
  - done and the new result appear in cycle 34.
  - Latency is 34 cycles.
- Fast path: done in cycle 1 with the result valid; busy stays low.
- done and busy are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- The ALU_DIV, ALU_DIVU, ALU_REM and ALU_REMU codes come from the shared parameters header. No new encodings are introduced.
- The state encodings are local parameters of this module.
- The block is a single module. An optional sub-module, div_step, holds the combinational shift/trial-subtract of one iteration so it can be reused for a future radix-4 variant.

## Test plan
- DIVU a = 100, b = 7 -> done in cycle 34, result 14; REMU with the same operands -> 2.
- DIV a = 0xFFFFFFF9 (−7), b = 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD; REM 7 / 0xFFFFFFFE -> 1.
- Divide by zero: DIV 5 / 0 -> 0xFFFFFFFF with done in cycle 1 and busy never high; REMU 5 / 0 -> 5.
- Overflow and unsigned boundary:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done in cycle 1.
  - REM with the same operands -> 0.
  - DIVU 0x80000000 / 0xFFFFFFFF -> 0, via the full 34-cycle path.
- Control:
  - flush in cycle 10 -> state IDLE in cycle 11, no done, result unchanged.
  - start during busy -> ignored.
  - start in the DONE cycle -> second done exactly 34 cycles later.
- Reset: reset_n low in cycle 20 of an operation -> busy = 0, done = 0 and result = 0 immediately. No done after release. A fresh DIVU 9 / 3 then yields 3.
